piso_shift: RTL and testbench
=============================

PISO_SHIFT -- requirements
Module: piso_shift

Interface
REQ-001 SHALL have parameter: WIDTH, 5, number of data bits per word (minimum 2).
REQ-002 SHALL have port: clock  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: data_i  input  WIDTH  parallel word to serialize.
REQ-005 SHALL have port: valid_i  input  1  data_i holds a word to load.
REQ-006 SHALL have port: ready_o  output  1  block can accept a word this cycle.
REQ-007 SHALL have port: data_o  output  1  serial bit, MSB first.
REQ-008 SHALL have port: valid_o  output  1  data_o carries a valid bit this cycle.
REQ-009 SHALL have port: last_o  output  1  current bit is the final bit of the frame.

Function
REQ-010 SHALL implement two states: IDLE and SHIFT.
REQ-011 SHALL accept a word at the rising edge where valid_i=1 and ready_o=1 (a "load"); data_i is ignored otherwise.
REQ-012 SHALL drive ready_o=1 in IDLE, and in SHIFT only during the cycle where last_o=1; otherwise 0.
REQ-013 SHALL drive data_o, valid_o and last_o from registers (no combinational path from inputs).
REQ-014 On a load at edge N, SHALL present data_i[WIDTH-1] with valid_o=1 in cycle N+1, then data_i[WIDTH-2] down to data_i[0] in cycles N+2 to N+WIDTH (one bit per cycle, no gaps).
REQ-015 SHALL keep the loaded word unaffected by data_i changes after the load edge.
REQ-016 SHALL hold a bit counter that counts frame bits sent and clears on every load.
REQ-017 SHALL assert last_o together with the final frame bit only.
REQ-018 Load in IDLE: transition to SHIFT at the load edge.
REQ-019 Final bit with valid_i=1: reload at that edge, stay in SHIFT, and emit the new MSB in the next cycle (back-to-back frames, valid_o stays 1).
REQ-020 Final bit with valid_i=0: return to IDLE; in the next cycle valid_o=0, last_o=0 and data_o=0.
REQ-021 In IDLE, SHALL hold data_o=0, valid_o=0 and last_o=0.
REQ-022 The bit order SHALL mean a serial-in shift register of WIDTH bits that inserts at bit 0 reconstructs data_i exactly after WIDTH valid bits.

Reset
REQ-023 On reset=1, SHALL immediately (without clock) set state=IDLE, counter=0, shift register=0, data_o=0, valid_o=0, last_o=0.
REQ-024 SHALL drive ready_o=0 while reset=1, and drive ready_o=1 in the first cycle after reset deasserts.
REQ-025 Reset asserted mid-frame SHALL abandon the frame; no remaining bits are emitted after release.

Configuration
REQ-026 Macro PISO_SHIFT_PARITY_EN SHALL control the parity bit.
REQ-027 With PISO_SHIFT_PARITY_EN defined, frame = WIDTH data bits plus one even-parity bit (XOR of the loaded word) in cycle N+WIDTH+1; last_o and the reload window (REQ-019) move to the parity bit.
REQ-028 Without PISO_SHIFT_PARITY_EN, frame = WIDTH data bits only; no parity logic is present.

Verification
REQ-029 Single frame, WIDTH=5, no parity: load 5'b10110 in IDLE -> data_o 1,0,1,1,0 in cycles N+1..N+5; valid_o=1 throughout; last_o=1 only in N+5; IDLE in N+6.
REQ-030 Back-to-back frames: load 5'b11001, hold valid_i=1 with 5'b00111 available -> second load at the last-bit edge; 10 contiguous valid bits 1,1,0,0,1,0,0,1,1,1.
REQ-031 Busy: valid_i=1 with new data during the non-last SHIFT cycles -> ready_o=0; data ignored; output stream unchanged.
REQ-032 Async reset at cycle N+3 of the 5'b10110 frame -> outputs zero before the next edge; ready_o=1 after release; no residual bits.
REQ-033 Parity (PISO_SHIFT_PARITY_EN): load 5'b10110 -> bits 1,0,1,1,0,1; last_o on the 6th bit. Load 5'b10100 -> parity bit 0.
REQ-034 Loopback: feed data_o/valid_o into a 5-bit serial-in shift register for 100 random words -> the register equals the loaded word after each last_o.

Source files
------------

// File: rtl/piso_shift.sv
// Parallel-in serial-out shifter: one word per frame, MSB first, with a valid/ready load handshake.
// Define PISO_SHIFT_PARITY_EN to append an even-parity bit to each frame.
module piso_shift #(
    parameter int WIDTH = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             data_o,
    output logic             valid_o,
    output logic             last_o
);

`ifdef PISO_SHIFT_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(FRAME);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             load;
`ifdef PISO_SHIFT_PARITY_EN
    logic             parity_q, parity_d;
`endif

    // The final bit's cycle doubles as the reload window, so frames can abut.
    assign ready_o = !reset && (state_q == IDLE || last_q);
    assign load    = valid_i && ready_o;
    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        data_d   = 1'b0;
        valid_d  = 1'b0;
        last_d   = 1'b0;
`ifdef PISO_SHIFT_PARITY_EN
        parity_d = parity_q;
`endif
        if (load) begin
            state_d  = SHIFT;
            cnt_d    = '0;
            data_d   = data_i[WIDTH-1];
            shreg_d  = {data_i[WIDTH-2:0], 1'b0};
            valid_d  = 1'b1;
`ifdef PISO_SHIFT_PARITY_EN
            parity_d = ^data_i;
`endif
        end else if (state_q == SHIFT) begin
            if (last_q) begin
                state_d = IDLE;
                cnt_d   = '0;
                shreg_d = '0;
            end else begin
                // cnt_q counts bits already completed; the bit being set up is index cnt_q+1.
                cnt_d   = cnt_q + CW'(1);
                valid_d = 1'b1;
                last_d  = (cnt_q == CW'(FRAME - 2));
`ifdef PISO_SHIFT_PARITY_EN
                if (cnt_q == CW'(WIDTH - 1)) begin
                    data_d = parity_q;
                end else
`endif
                begin
                    data_d  = shreg_q[WIDTH-1];
                    shreg_d = shreg_q << 1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            data_q   <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
`ifdef PISO_SHIFT_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
`ifdef PISO_SHIFT_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_piso_shift.sv
// Randomized self-checking bench for piso_shift; the reference model is a queue of pending frame bits.
module tb_piso_shift;
    localparam int WIDTH = 5;
`ifdef PISO_SHIFT_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] data_i = '0;
    logic             valid_i = 1'b0;
    logic             ready_o, data_o, valid_o, last_o;

    int checks = 0;
    int errors = 0;

    // Model: q[0] is the bit on data_o this cycle, the rest are still to come.
    bit               q[$];
    logic [WIDTH-1:0] cur_word;
    logic [FRAME-1:0] loop_sr;
    int               loads;

    piso_shift #(.WIDTH(WIDTH)) dut (
        .clock(clock), .reset(reset), .data_i(data_i), .valid_i(valid_i),
        .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o), .last_o(last_o)
    );

    always #5 clock = ~clock;

    task automatic push_frame(input logic [WIDTH-1:0] w);
        q.delete();
        for (int i = WIDTH - 1; i >= 0; i--) q.push_back(w[i]);
`ifdef PISO_SHIFT_PARITY_EN
        q.push_back(^w);
`endif
        cur_word = w;
    endtask

    task automatic check_outputs(input string tag);
        logic exp_v, exp_d, exp_l, exp_r;
        exp_v = (q.size() > 0);
        exp_d = (q.size() > 0) ? q[0] : 1'b0;
        exp_l = (q.size() == 1);
        exp_r = !reset && (q.size() <= 1);
        checks += 4;
        if (valid_o !== exp_v) begin errors++; $display("FAIL %s valid_o: got %b expected %b", tag, valid_o, exp_v); end
        if (data_o  !== exp_d) begin errors++; $display("FAIL %s data_o: got %b expected %b", tag, data_o, exp_d); end
        if (last_o  !== exp_l) begin errors++; $display("FAIL %s last_o: got %b expected %b", tag, last_o, exp_l); end
        if (ready_o !== exp_r) begin errors++; $display("FAIL %s ready_o: got %b expected %b", tag, ready_o, exp_r); end
    endtask

    // One cycle: drive inputs just after a negedge, check, then advance the model at the posedge.
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input string tag);
        logic do_load;
        valid_i = v;
        data_i  = d;
        #1;
        check_outputs(tag);
        if (valid_o) begin
            loop_sr = {loop_sr[FRAME-2:0], data_o};
            if (last_o) begin
                checks++;
                if ((loop_sr >> (FRAME - WIDTH)) !== FRAME'(cur_word)) begin
                    errors++;
                    $display("FAIL %s loopback: got %h expected %h", tag, loop_sr >> (FRAME - WIDTH), cur_word);
                end
            end
        end
        do_load = v && (q.size() <= 1);
        @(posedge clock);
        if (do_load) begin push_frame(d); loads++; end
        else if (q.size() > 0) void'(q.pop_front());
        @(negedge clock);
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        checks += 4;
        if (valid_o !== 1'b0) begin errors++; $display("FAIL reset valid_o: got %b expected 0", valid_o); end
        if (data_o  !== 1'b0) begin errors++; $display("FAIL reset data_o: got %b expected 0", data_o); end
        if (last_o  !== 1'b0) begin errors++; $display("FAIL reset last_o: got %b expected 0", last_o); end
        if (ready_o !== 1'b0) begin errors++; $display("FAIL reset ready_o: got %b expected 0", ready_o); end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        q.delete();
        step(1'b0, '0, "post_reset");
    endtask

    task automatic test_single();
        step(1'b1, 5'b10110, "single_load");
        for (int i = 0; i < FRAME + 1; i++) step(1'b0, 5'($urandom), "single_shift");
    endtask

    task automatic test_back_to_back();
        step(1'b1, 5'b11001, "b2b_load1");
        for (int i = 0; i < FRAME - 1; i++) step(1'b1, 5'b00111, "b2b_hold");
        step(1'b1, 5'b00111, "b2b_reload");
        for (int i = 0; i < FRAME; i++) step(1'b0, '0, "b2b_drain");
    endtask

    task automatic test_busy();
        step(1'b1, 5'($urandom), "busy_load");
        for (int i = 0; i < FRAME - 1; i++) step(1'b1, 5'($urandom), "busy_ignored");
        step(1'b0, '0, "busy_last");
        step(1'b0, '0, "busy_idle");
    endtask

    task automatic test_parity_zero();
        step(1'b1, 5'b10100, "par_load");
        for (int i = 0; i < FRAME + 1; i++) step(1'b0, '0, "par_shift");
    endtask

    task automatic test_mid_reset();
        step(1'b1, 5'b10110, "rst_load");
        step(1'b0, '0, "rst_n2");
        step(1'b0, '0, "rst_n3");
        #2 reset = 1'b1;
        #1;
        checks += 4;
        if (valid_o !== 1'b0) begin errors++; $display("FAIL midrst valid_o: got %b expected 0", valid_o); end
        if (data_o  !== 1'b0) begin errors++; $display("FAIL midrst data_o: got %b expected 0", data_o); end
        if (last_o  !== 1'b0) begin errors++; $display("FAIL midrst last_o: got %b expected 0", last_o); end
        if (ready_o !== 1'b0) begin errors++; $display("FAIL midrst ready_o: got %b expected 0", ready_o); end
        q.delete();
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < FRAME; i++) step(1'b0, '0, "rst_residual");
    endtask

    task automatic test_loopback();
        int cycles = 0;
        int start = loads;
        while (loads - start < 100 && cycles < 5000) begin
            step(($urandom_range(0, 9) < 7), 5'($urandom), "loopback");
            cycles++;
        end
        for (int i = 0; i < FRAME + 1; i++) step(1'b0, '0, "loopback_drain");
        checks++;
        if (loads - start < 100) begin
            errors++;
            $display("FAIL loopback_budget: got %0d loads expected 100", loads - start);
        end
    endtask

    initial begin
        loop_sr = '0;
        cur_word = '0;
        loads = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_busy();
        test_parity_zero();
        test_mid_reset();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
